// File: rtl/rf_pkg.sv
// Shared register-file types for the writeback path.
package rf_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        xlen_t     data;
    } wb_req_t;

    typedef enum logic {
        PRIO_WB0 = 1'b0,
        PRIO_WB1 = 1'b1
    } prio_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations, with hazard lookups
// and a sticky flag for LSU writes to registers that were never marked pending.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t chk_rs1,
    input  reg_addr_t chk_rs2,
    input  reg_addr_t chk_rd,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      rd_busy,
    output logic      sb_err
);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Set is applied after clear so a newly issued op stays outstanding.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) sb_d[clr_rd] = 1'b0;
        if (set_en) sb_d[set_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q   <= '0;
            sb_err <= 1'b0;
        end else begin
            sb_q <= sb_d;
            if (clr_en && (clr_rd != '0) && !sb_q[clr_rd]) sb_err <= 1'b1;
        end
    end

    assign rs1_busy = sb_q[chk_rs1];
    assign rs2_busy = sb_q[chk_rs2];
    assign rd_busy  = sb_q[chk_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbitration of ALU and LSU writebacks onto the single
// register-file write port, with a registered write stage.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wb0_valid,
    input  reg_addr_t wb0_rd,
    input  xlen_t     wb0_data,
    output logic      wb0_ready,
    input  logic      wb1_valid,
    input  reg_addr_t wb1_rd,
    input  xlen_t     wb1_data,
    output logic      wb1_ready,
    input  logic      sb_set,
    input  reg_addr_t sb_set_rd,
    input  reg_addr_t chk_rs1,
    input  reg_addr_t chk_rs2,
    input  reg_addr_t chk_rd,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      rd_busy,
    output logic      rf_en,
    output reg_addr_t rf_rd,
    output xlen_t     rf_wdata,
    output logic      sb_err
);

    wb_req_t req0, req1, win;
    prio_e   prio_q, prio_d;
    logic    grant0, grant1;

    always_comb begin
        req0   = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
        req1   = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};
        grant0 = req0.valid && (!req1.valid || (prio_q == PRIO_WB0));
        grant1 = req1.valid && (!req0.valid || (prio_q == PRIO_WB1));
        // Priority only moves on contention, and always towards the loser.
        prio_d = prio_q;
        if (req0.valid && req1.valid) prio_d = grant0 ? PRIO_WB1 : PRIO_WB0;
        win       = grant1 ? req1 : req0;
        win.valid = grant0 || grant1;
    end

    assign wb0_ready = grant0;
    assign wb1_ready = grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= PRIO_WB0;
        else        prio_q <= prio_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_en <= win.valid && (win.rd != '0);
            if (win.valid) begin
                rf_rd    <= win.rd;
                rf_wdata <= win.data;
            end
        end
    end

    rf_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_rd   (sb_set_rd),
        .clr_en   (grant1),
        .clr_rd   (wb1_rd),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .chk_rd   (chk_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .sb_err   (sb_err)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: per-cycle vector table plus hand-written
// reset and contention sequences.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd, sb_set_rd, chk_rs1, chk_rs2, chk_rd, rf_rd;
    logic [31:0] wb0_data, wb1_data, rf_wdata;
    logic        sb_set, rs1_busy, rs2_busy, rd_busy, rf_en, sb_err;

    int n_chk  = 0;
    int n_fail = 0;

    rf_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .sb_set(sb_set), .sb_set_rd(sb_set_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v0; logic [4:0] rd0; logic [31:0] d0;
        logic v1; logic [4:0] rd1; logic [31:0] d1;
        logic set; logic [4:0] set_rd; logic [4:0] chk;
        logic r0; logic r1;
        logic en; logic [4:0] rd; logic [31:0] data;
        logic busy; logic err;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
        input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
        input logic set, input logic [4:0] set_rd, input logic [4:0] chk,
        input logic r0, input logic r1,
        input logic en, input logic [4:0] rd, input logic [31:0] data,
        input logic busy, input logic err);
        vec_t v;
        v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
        v.set = set; v.set_rd = set_rd; v.chk = chk; v.r0 = r0; v.r1 = r1;
        v.en = en; v.rd = rd; v.data = data; v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb0_valid = v.v0; wb0_rd = v.rd0; wb0_data = v.d0;
        wb1_valid = v.v1; wb1_rd = v.rd1; wb1_data = v.d1;
        sb_set = v.set; sb_set_rd = v.set_rd;
        chk_rs1 = v.chk; chk_rs2 = v.chk; chk_rd = v.chk;
    endtask

    task automatic check_busy(input string tag, input logic exp);
        check({tag, " rs1_busy"}, {31'd0, rs1_busy}, {31'd0, exp});
        check({tag, " rs2_busy"}, {31'd0, rs2_busy}, {31'd0, exp});
        check({tag, " rd_busy"},  {31'd0, rd_busy},  {31'd0, exp});
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          v0 rd0 d0            v1 rd1 d1            set srd chk r0 r1 en rd  data          busy err
        vecs[0]  = idle;
        vecs[1]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0,  0,  1, 0, 1, 5,  32'hDEADBEEF, 0, 0);
        vecs[2]  = idle;
        vecs[3]  = mk(0, 0, 0,            0, 0, 0,            1, 7,  7,  0, 0, 0, 0,  0,            1, 0);
        vecs[4]  = mk(0, 0, 0,            1, 7, 32'hA5A5A5A5, 0, 0,  7,  0, 1, 1, 7,  32'hA5A5A5A5, 0, 0);
        vecs[5]  = mk(0, 0, 0,            0, 0, 0,            1, 9,  9,  0, 0, 0, 0,  0,            1, 0);
        vecs[6]  = mk(0, 0, 0,            1, 9, 32'h00000099, 1, 9,  9,  0, 1, 1, 9,  32'h00000099, 1, 0);
        vecs[7]  = mk(0, 0, 0,            1, 9, 32'h0000009A, 0, 0,  9,  0, 1, 1, 9,  32'h0000009A, 0, 0);
        vecs[8]  = mk(1, 0, 32'h1234,     0, 0, 0,            0, 0,  0,  1, 0, 0, 0,  0,            0, 0);
        vecs[9]  = mk(0, 0, 0,            1, 0, 32'h5678,     1, 0,  0,  0, 1, 0, 0,  0,            0, 0);
        vecs[10] = mk(0, 0, 0,            1, 12, 32'h00C0FFEE, 0, 0, 12, 0, 1, 1, 12, 32'h00C0FFEE, 0, 1);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,            0, 0,  12, 0, 0, 0, 0,  0,            0, 1);

        drive(idle);
        rst_n = 1'b0;
        #1;
        check("reset rf_en", {31'd0, rf_en}, 32'd0);
        check("reset rf_rd", {27'd0, rf_rd}, 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        check("reset sb_err", {31'd0, sb_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check({tag, " wb0_ready"}, {31'd0, wb0_ready}, {31'd0, vecs[i].r0});
            check({tag, " wb1_ready"}, {31'd0, wb1_ready}, {31'd0, vecs[i].r1});
            @(posedge clk);
            #1;
            check({tag, " rf_en"}, {31'd0, rf_en}, {31'd0, vecs[i].en});
            if (vecs[i].en) begin
                check({tag, " rf_rd"}, {27'd0, rf_rd}, {27'd0, vecs[i].rd});
                check({tag, " rf_wdata"}, rf_wdata, vecs[i].data);
            end
            check_busy(tag, vecs[i].busy);
            check({tag, " sb_err"}, {31'd0, sb_err}, {31'd0, vecs[i].err});
        end

        // Asynchronous reset while a write is in flight and a register is pending.
        @(negedge clk);
        drive(mk(1, 5, 32'h55, 0, 0, 0, 1, 20, 20, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("pre-reset rf_en", {31'd0, rf_en}, 32'd1);
        check_busy("pre-reset", 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async rf_en", {31'd0, rf_en}, 32'd0);
        check("async sb_err", {31'd0, sb_err}, 32'd0);
        check_busy("async", 1'b0);
        @(posedge clk);
        #1;
        check("in-reset rf_en", {31'd0, rf_en}, 32'd0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-release rf_en", {31'd0, rf_en}, 32'd0);
        check_busy("post-release", 1'b0);

        // Continuous contention: grants must alternate starting with wb0.
        @(negedge clk);
        drive(mk(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            string tag;
            logic even;
            tag  = $sformatf("cont%0d", i);
            even = (i % 2 == 0);
            #1;
            check({tag, " wb0_ready"}, {31'd0, wb0_ready}, {31'd0, even});
            check({tag, " wb1_ready"}, {31'd0, wb1_ready}, {31'd0, ~even});
            @(posedge clk);
            #1;
            check({tag, " rf_en"}, {31'd0, rf_en}, 32'd1);
            check({tag, " rf_rd"}, {27'd0, rf_rd}, even ? 32'd3 : 32'd4);
            check({tag, " rf_wdata"}, rf_wdata, even ? 32'h11 : 32'h22);
            @(negedge clk);
        end
        check("cont sb_err", {31'd0, sb_err}, 32'd1);

        // A lone request must not disturb the priority left by contention.
        #1;
        check("prio A wb0_ready", {31'd0, wb0_ready}, 32'd1);
        @(negedge clk);
        wb1_valid = 1'b0;
        #1;
        check("prio B wb0_ready", {31'd0, wb0_ready}, 32'd1);
        @(negedge clk);
        wb1_valid = 1'b1;
        #1;
        check("prio C wb0_ready", {31'd0, wb0_ready}, 32'd0);
        check("prio C wb1_ready", {31'd0, wb1_ready}, 32'd1);
        @(negedge clk);
        drive(idle);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
